// File: rtl/lsu_pkg.sv
// Shared definitions for the load/store unit: RV32I width codes and FSM state encoding.
package lsu_pkg;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    RESP   = 2'd2
  } state_e;

endpackage

// File: rtl/lsu_align.sv
// Combinational lane logic: store replication/byte enables, load select/extension,
// and illegal/misaligned classification of a request.
module lsu_align
  import lsu_pkg::*;
(
  input  logic        is_store,
  input  logic [2:0]  funct3,
  input  logic [1:0]  addr_lo,
  input  logic [31:0] wdata,
  input  logic [31:0] rdata,
  output logic [3:0]  byte_en,
  output logic [31:0] wdata_lanes,
  output logic [31:0] rdata_ext,
  output logic        misaligned,
  output logic        illegal
);

  logic        mis_raw_s;
  logic [7:0]  byte_s;
  logic [15:0] half_s;

  // Classify the width code; misalignment is only reported for legal codes.
  always_comb begin
    illegal   = 1'b0;
    mis_raw_s = 1'b0;
    case (funct3)
      F3_B:         illegal = 1'b0;
      F3_W:         mis_raw_s = (addr_lo != 2'b00);
      F3_H:         mis_raw_s = addr_lo[0];
      F3_BU:        illegal = is_store;
      F3_HU: begin
        illegal   = is_store;
        mis_raw_s = addr_lo[0];
      end
      default:      illegal = 1'b1;
    endcase
    misaligned = mis_raw_s & ~illegal;
  end

  // Store lanes are replicated so the memory picks the right copy via byte_en.
  always_comb begin
    byte_en     = 4'b1111;
    wdata_lanes = wdata;
    if (is_store) begin
      case (funct3)
        F3_B: begin
          byte_en     = 4'b0001 << addr_lo;
          wdata_lanes = {4{wdata[7:0]}};
        end
        F3_H: begin
          byte_en     = addr_lo[1] ? 4'b1100 : 4'b0011;
          wdata_lanes = {2{wdata[15:0]}};
        end
        default: begin
          byte_en     = 4'b1111;
          wdata_lanes = wdata;
        end
      endcase
    end else begin
      byte_en     = 4'b1111;
      wdata_lanes = wdata;
    end
  end

  // Load lane select followed by sign/zero extension.
  always_comb begin
    case (addr_lo)
      2'd0:    byte_s = rdata[7:0];
      2'd1:    byte_s = rdata[15:8];
      2'd2:    byte_s = rdata[23:16];
      default: byte_s = rdata[31:24];
    endcase
    half_s = addr_lo[1] ? rdata[31:16] : rdata[15:0];
    case (funct3)
      F3_B:    rdata_ext = {{24{byte_s[7]}}, byte_s};
      F3_BU:   rdata_ext = {24'd0, byte_s};
      F3_H:    rdata_ext = {{16{half_s[15]}}, half_s};
      F3_HU:   rdata_ext = {16'd0, half_s};
      default: rdata_ext = rdata;
    endcase
  end

endmodule

// File: rtl/load_store_unit.sv
// Data-memory initiator: accepts one load/store at a time, performs a word-aligned
// access with byte enables, and returns an extended, registered response.
module load_store_unit
  import lsu_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYCLES = 16,
  parameter int unsigned ADDR_W         = 32
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_is_store,
  input  logic [2:0]        req_funct3,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [31:0]       req_wdata,
  output logic              resp_valid,
  output logic [31:0]       resp_rdata,
  output logic              resp_misaligned,
  output logic              resp_err,
  output logic              mem_read_en,
  output logic              mem_write_en,
  output logic [ADDR_W-1:0] mem_address,
  output logic [31:0]       mem_write_data,
  output logic [3:0]        mem_byte_en,
  input  logic [31:0]       mem_read_data,
  input  logic              mem_ready
);

  state_e            state_q, state_d;
  logic              req_ready_q, req_ready_d;
  logic              is_store_q, is_store_d;
  logic [2:0]        funct3_q, funct3_d;
  logic [1:0]        addr_lo_q, addr_lo_d;
  logic [31:0]       cnt_q, cnt_d;
  logic              resp_valid_q, resp_valid_d;
  logic [31:0]       resp_rdata_q, resp_rdata_d;
  logic              resp_mis_q, resp_mis_d;
  logic              resp_err_q, resp_err_d;
  logic              rd_en_q, rd_en_d;
  logic              wr_en_q, wr_en_d;
  logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
  logic [31:0]       mem_wdata_q, mem_wdata_d;
  logic [3:0]        mem_be_q, mem_be_d;

  logic              al_is_store_s;
  logic [2:0]        al_funct3_s;
  logic [1:0]        al_addr_lo_s;
  logic [3:0]        al_byte_en_s;
  logic [31:0]       al_wdata_s;
  logic [31:0]       al_rdata_s;
  logic              al_mis_s;
  logic              al_ill_s;
  logic              timeout_hit_s;

  // The aligner classifies the live request in IDLE and extends the held one afterwards.
  assign al_is_store_s = (state_q == IDLE) ? req_is_store      : is_store_q;
  assign al_funct3_s   = (state_q == IDLE) ? req_funct3        : funct3_q;
  assign al_addr_lo_s  = (state_q == IDLE) ? req_addr[1:0]     : addr_lo_q;

  lsu_align u_align (
    .is_store    (al_is_store_s),
    .funct3      (al_funct3_s),
    .addr_lo     (al_addr_lo_s),
    .wdata       (req_wdata),
    .rdata       (mem_read_data),
    .byte_en     (al_byte_en_s),
    .wdata_lanes (al_wdata_s),
    .rdata_ext   (al_rdata_s),
    .misaligned  (al_mis_s),
    .illegal     (al_ill_s)
  );

  assign timeout_hit_s = (TIMEOUT_CYCLES != 32'd0) && (cnt_q == TIMEOUT_CYCLES - 32'd1);

  // Next-state and registered-output computation for the IDLE/ACCESS/RESP sequence.
  always_comb begin
    state_d      = state_q;
    is_store_d   = is_store_q;
    funct3_d     = funct3_q;
    addr_lo_d    = addr_lo_q;
    cnt_d        = cnt_q;
    resp_valid_d = 1'b0;
    resp_rdata_d = resp_rdata_q;
    resp_mis_d   = resp_mis_q;
    resp_err_d   = resp_err_q;
    rd_en_d      = rd_en_q;
    wr_en_d      = wr_en_q;
    mem_addr_d   = mem_addr_q;
    mem_wdata_d  = mem_wdata_q;
    mem_be_d     = mem_be_q;
    case (state_q)
      IDLE: begin
        if (req_valid) begin
          is_store_d = req_is_store;
          funct3_d   = req_funct3;
          addr_lo_d  = req_addr[1:0];
          cnt_d      = 32'd0;
          if (al_ill_s || al_mis_s) begin
            state_d      = RESP;
            resp_valid_d = 1'b1;
            resp_rdata_d = 32'd0;
            resp_err_d   = al_ill_s;
            resp_mis_d   = al_mis_s;
          end else begin
            state_d     = ACCESS;
            rd_en_d     = ~req_is_store;
            wr_en_d     = req_is_store;
            mem_addr_d  = {req_addr[ADDR_W-1:2], 2'b00};
            mem_wdata_d = al_wdata_s;
            mem_be_d    = al_byte_en_s;
          end
        end else begin
          state_d = IDLE;
        end
      end
      ACCESS: begin
        if (mem_ready) begin
          state_d      = RESP;
          rd_en_d      = 1'b0;
          wr_en_d      = 1'b0;
          cnt_d        = 32'd0;
          resp_valid_d = 1'b1;
          resp_rdata_d = is_store_q ? 32'd0 : al_rdata_s;
          resp_err_d   = 1'b0;
          resp_mis_d   = 1'b0;
        end else if (timeout_hit_s) begin
          state_d      = RESP;
          rd_en_d      = 1'b0;
          wr_en_d      = 1'b0;
          cnt_d        = 32'd0;
          resp_valid_d = 1'b1;
          resp_rdata_d = 32'd0;
          resp_err_d   = 1'b1;
          resp_mis_d   = 1'b0;
        end else begin
          cnt_d = cnt_q + 32'd1;
        end
      end
      RESP: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
        rd_en_d = 1'b0;
        wr_en_d = 1'b0;
        cnt_d   = 32'd0;
      end
    endcase
    req_ready_d = (state_d == IDLE);
  end

  // State and output registers; reset abandons any access in flight.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      req_ready_q  <= 1'b1;
      is_store_q   <= 1'b0;
      funct3_q     <= 3'd0;
      addr_lo_q    <= 2'd0;
      cnt_q        <= 32'd0;
      resp_valid_q <= 1'b0;
      resp_rdata_q <= 32'd0;
      resp_mis_q   <= 1'b0;
      resp_err_q   <= 1'b0;
      rd_en_q      <= 1'b0;
      wr_en_q      <= 1'b0;
      mem_addr_q   <= '0;
      mem_wdata_q  <= 32'd0;
      mem_be_q     <= 4'd0;
    end else begin
      state_q      <= state_d;
      req_ready_q  <= req_ready_d;
      is_store_q   <= is_store_d;
      funct3_q     <= funct3_d;
      addr_lo_q    <= addr_lo_d;
      cnt_q        <= cnt_d;
      resp_valid_q <= resp_valid_d;
      resp_rdata_q <= resp_rdata_d;
      resp_mis_q   <= resp_mis_d;
      resp_err_q   <= resp_err_d;
      rd_en_q      <= rd_en_d;
      wr_en_q      <= wr_en_d;
      mem_addr_q   <= mem_addr_d;
      mem_wdata_q  <= mem_wdata_d;
      mem_be_q     <= mem_be_d;
    end
  end

  assign req_ready       = req_ready_q;
  assign resp_valid      = resp_valid_q;
  assign resp_rdata      = resp_rdata_q;
  assign resp_misaligned = resp_mis_q;
  assign resp_err        = resp_err_q;
  assign mem_read_en     = rd_en_q;
  assign mem_write_en    = wr_en_q;
  assign mem_address     = mem_addr_q;
  assign mem_write_data  = mem_wdata_q;
  assign mem_byte_en     = mem_be_q;

endmodule

// File: tb/tb_load_store_unit.sv
// Directed bench for load_store_unit: one task per scenario with hand-computed expectations.
module tb_load_store_unit;

  logic        clk;
  logic        rst_n;
  logic        req_valid;
  logic        req_ready;
  logic        req_is_store;
  logic [2:0]  req_funct3;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic        resp_valid;
  logic [31:0] resp_rdata;
  logic        resp_misaligned;
  logic        resp_err;
  logic        mem_read_en;
  logic        mem_write_en;
  logic [31:0] mem_address;
  logic [31:0] mem_write_data;
  logic [3:0]  mem_byte_en;
  logic [31:0] mem_read_data;
  logic        mem_ready;

  int n_checks = 0;
  int n_fail   = 0;

  load_store_unit #(.TIMEOUT_CYCLES(16), .ADDR_W(32)) dut (
    .clk             (clk),
    .rst_n           (rst_n),
    .req_valid       (req_valid),
    .req_ready       (req_ready),
    .req_is_store    (req_is_store),
    .req_funct3      (req_funct3),
    .req_addr        (req_addr),
    .req_wdata       (req_wdata),
    .resp_valid      (resp_valid),
    .resp_rdata      (resp_rdata),
    .resp_misaligned (resp_misaligned),
    .resp_err        (resp_err),
    .mem_read_en     (mem_read_en),
    .mem_write_en    (mem_write_en),
    .mem_address     (mem_address),
    .mem_write_data  (mem_write_data),
    .mem_byte_en     (mem_byte_en),
    .mem_read_data   (mem_read_data),
    .mem_ready       (mem_ready)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Present a request on a falling edge, let it be accepted, and return on the next falling edge.
  task automatic drive_req(input logic st, input logic [2:0] f3, input logic [31:0] a,
                           input logic [31:0] wd);
    @(negedge clk);
    req_is_store = st;
    req_funct3   = f3;
    req_addr     = a;
    req_wdata    = wd;
    req_valid    = 1'b1;
    @(posedge clk);
    @(negedge clk);
    req_valid = 1'b0;
  endtask

  task automatic test_reset;
    rst_n = 1'b0;
    #12;
    n_checks++; if (req_ready !== 1'b1) begin n_fail++; $display("FAIL reset_req_ready got %b want 1", req_ready); end
    n_checks++; if (resp_valid !== 1'b0) begin n_fail++; $display("FAIL reset_resp_valid got %b want 0", resp_valid); end
    n_checks++; if ({mem_read_en, mem_write_en} !== 2'b00) begin n_fail++; $display("FAIL reset_strobes got %b want 00", {mem_read_en, mem_write_en}); end
    n_checks++; if ({mem_address, mem_byte_en, resp_rdata} !== 68'd0) begin n_fail++; $display("FAIL reset_data got %h want 0", {mem_address, mem_byte_en, resp_rdata}); end
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_sw;
    mem_ready = 1'b1;
    drive_req(1'b1, 3'b010, 32'h10, 32'hDEADBEEF);
    n_checks++; if ({mem_write_en, mem_read_en} !== 2'b10) begin n_fail++; $display("FAIL sw_strobes got %b want 10", {mem_write_en, mem_read_en}); end
    n_checks++; if (mem_address !== 32'h10) begin n_fail++; $display("FAIL sw_addr got %h want 00000010", mem_address); end
    n_checks++; if (mem_byte_en !== 4'b1111) begin n_fail++; $display("FAIL sw_be got %b want 1111", mem_byte_en); end
    n_checks++; if (mem_write_data !== 32'hDEADBEEF) begin n_fail++; $display("FAIL sw_wdata got %h want deadbeef", mem_write_data); end
    n_checks++; if (resp_valid !== 1'b0) begin n_fail++; $display("FAIL sw_early_resp got %b want 0", resp_valid); end
    @(negedge clk);
    n_checks++; if (resp_valid !== 1'b1) begin n_fail++; $display("FAIL sw_resp_valid got %b want 1", resp_valid); end
    n_checks++; if ({resp_rdata, resp_err, resp_misaligned} !== 34'd0) begin n_fail++; $display("FAIL sw_resp got %h want 0", {resp_rdata, resp_err, resp_misaligned}); end
    n_checks++; if (mem_write_en !== 1'b0) begin n_fail++; $display("FAIL sw_strobe_drop got %b want 0", mem_write_en); end
    @(negedge clk);
    n_checks++; if ({resp_valid, req_ready} !== 2'b01) begin n_fail++; $display("FAIL sw_idle got %b want 01", {resp_valid, req_ready}); end
  endtask

  task automatic test_sb_sh;
    mem_ready = 1'b1;
    drive_req(1'b1, 3'b000, 32'h13, 32'h000000A5);
    n_checks++; if (mem_write_data !== 32'hA5A5A5A5) begin n_fail++; $display("FAIL sb_wdata got %h want a5a5a5a5", mem_write_data); end
    n_checks++; if (mem_byte_en !== 4'b1000) begin n_fail++; $display("FAIL sb_be got %b want 1000", mem_byte_en); end
    n_checks++; if (mem_address !== 32'h10) begin n_fail++; $display("FAIL sb_addr got %h want 00000010", mem_address); end
    @(negedge clk);
    @(negedge clk);
    drive_req(1'b1, 3'b001, 32'h22, 32'h1234CAFE);
    n_checks++; if (mem_write_data !== 32'hCAFECAFE) begin n_fail++; $display("FAIL sh_wdata got %h want cafecafe", mem_write_data); end
    n_checks++; if (mem_byte_en !== 4'b1100) begin n_fail++; $display("FAIL sh_be got %b want 1100", mem_byte_en); end
    n_checks++; if (mem_address !== 32'h20) begin n_fail++; $display("FAIL sh_addr got %h want 00000020", mem_address); end
    @(negedge clk);
    @(negedge clk);
  endtask

  task automatic test_loads;
    logic [2:0]  f3_tab [5]  = '{3'b000, 3'b100, 3'b001, 3'b101, 3'b100};
    logic [31:0] adr_tab [5] = '{32'h13, 32'h13, 32'h12, 32'h10, 32'h11};
    logic [31:0] exp_tab [5] = '{32'hFFFFFF80, 32'h00000080, 32'hFFFF80FF, 32'h00007F01, 32'h0000007F};
    mem_ready     = 1'b1;
    mem_read_data = 32'h80FF7F01;
    for (int i = 0; i < 5; i++) begin
      drive_req(1'b0, f3_tab[i], adr_tab[i], 32'd0);
      n_checks++; if ({mem_read_en, mem_write_en, mem_byte_en} !== 6'b101111) begin n_fail++; $display("FAIL load%0d_mem got %b want 101111", i, {mem_read_en, mem_write_en, mem_byte_en}); end
      @(negedge clk);
      n_checks++; if (resp_valid !== 1'b1 || resp_rdata !== exp_tab[i]) begin n_fail++; $display("FAIL load%0d_data got v=%b %h want v=1 %h", i, resp_valid, resp_rdata, exp_tab[i]); end
      @(negedge clk);
    end
  endtask

  task automatic test_errors;
    mem_ready = 1'b1;
    drive_req(1'b0, 3'b010, 32'h22, 32'd0);
    n_checks++; if ({resp_valid, resp_misaligned, resp_err} !== 3'b110) begin n_fail++; $display("FAIL lw_misaligned got %b want 110", {resp_valid, resp_misaligned, resp_err}); end
    n_checks++; if (mem_read_en !== 1'b0) begin n_fail++; $display("FAIL lw_misaligned_no_read got %b want 0", mem_read_en); end
    @(negedge clk);
    drive_req(1'b0, 3'b011, 32'h0, 32'd0);
    n_checks++; if ({resp_valid, resp_misaligned, resp_err} !== 3'b101 || resp_rdata !== 32'd0) begin n_fail++; $display("FAIL load_f3_011 got %b %h want 101 0", {resp_valid, resp_misaligned, resp_err}, resp_rdata); end
    @(negedge clk);
    drive_req(1'b1, 3'b100, 32'h1, 32'd0);
    n_checks++; if ({resp_valid, resp_misaligned, resp_err, mem_write_en} !== 4'b1010) begin n_fail++; $display("FAIL store_f3_100 got %b want 1010", {resp_valid, resp_misaligned, resp_err, mem_write_en}); end
    @(negedge clk);
  endtask

  task automatic test_stall;
    mem_ready     = 1'b0;
    mem_read_data = 32'h12345678;
    drive_req(1'b0, 3'b010, 32'h40, 32'd0);
    for (int i = 0; i < 3; i++) begin
      n_checks++; if ({mem_read_en, mem_address, mem_byte_en, resp_valid} !== {1'b1, 32'h40, 4'b1111, 1'b0}) begin n_fail++; $display("FAIL stall%0d got re=%b a=%h be=%b v=%b", i, mem_read_en, mem_address, mem_byte_en, resp_valid); end
      @(negedge clk);
    end
    mem_ready = 1'b1;
    @(negedge clk);
    n_checks++; if ({resp_valid, resp_err} !== 2'b10 || resp_rdata !== 32'h12345678) begin n_fail++; $display("FAIL stall_resp got %b %h want 10 12345678", {resp_valid, resp_err}, resp_rdata); end
    @(negedge clk);
  endtask

  task automatic test_timeout;
    int n;
    mem_ready = 1'b0;
    drive_req(1'b0, 3'b010, 32'h44, 32'd0);
    n = 0;
    while (mem_read_en === 1'b1 && n < 40) begin
      n++;
      @(negedge clk);
    end
    n_checks++; if (n !== 16) begin n_fail++; $display("FAIL timeout_cycles got %0d want 16", n); end
    n_checks++; if ({resp_valid, resp_err, resp_misaligned} !== 3'b110 || resp_rdata !== 32'd0) begin n_fail++; $display("FAIL timeout_resp got %b %h want 110 0", {resp_valid, resp_err, resp_misaligned}, resp_rdata); end
    mem_ready = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_reset_mid_access;
    mem_ready = 1'b0;
    drive_req(1'b1, 3'b010, 32'h80, 32'h11223344);
    n_checks++; if (mem_write_en !== 1'b1) begin n_fail++; $display("FAIL rst_mid_pre got %b want 1", mem_write_en); end
    #2 rst_n = 1'b0;
    #1;
    n_checks++; if ({mem_write_en, req_ready, resp_valid} !== 3'b010) begin n_fail++; $display("FAIL rst_mid_drop got %b want 010", {mem_write_en, req_ready, resp_valid}); end
    @(negedge clk);
    rst_n     = 1'b1;
    mem_ready = 1'b1;
    @(negedge clk);
    @(negedge clk);
    n_checks++; if ({req_ready, resp_valid, mem_write_en} !== 3'b100) begin n_fail++; $display("FAIL rst_mid_after got %b want 100", {req_ready, resp_valid, mem_write_en}); end
  endtask

  initial begin
    req_valid     = 1'b0;
    req_is_store  = 1'b0;
    req_funct3    = 3'd0;
    req_addr      = 32'd0;
    req_wdata     = 32'd0;
    mem_read_data = 32'd0;
    mem_ready     = 1'b1;
    test_reset();
    test_sw();
    test_sb_sh();
    test_loads();
    test_errors();
    test_stall();
    test_timeout();
    test_reset_mid_access();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/load_store_unit.md
Name: load_store_unit

Overview:
- Initiator side of the CPU data-memory interface.
- Accepts one load/store request at a time from the execute/memory pipeline stage.
- Converts each request into word-aligned memory accesses with byte enables, waits for the memory to complete, then returns sign- or zero-extended load data.
- Sits between the pipeline MEM stage and the word-organised data memory. Flags misaligned, illegal and timed-out accesses.

Parameters:
- TIMEOUT_CYCLES, 16: cycles in ACCESS without mem_ready before a bus error is returned. 0 disables the timeout.
- ADDR_W, 32: byte-address width.

Ports:
- clk  in  1  system clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- req_valid  in  1  pipeline presents a request.
- req_ready  out  1  unit can accept a request. High only in IDLE.
- req_is_store  in  1  1 = store, 0 = load.
- req_funct3  in  3  RV32I width code: 000 B, 001 H, 010 W, 100 BU, 101 HU.
- req_addr  in  ADDR_W  byte address from the ALU.
- req_wdata  in  32  store data from rs2.
- resp_valid  out  1  one-cycle completion pulse.
- resp_rdata  out  32  extended load data. 0 for stores and errors.
- resp_misaligned  out  1  access was misaligned. No memory access was made.
- resp_err  out  1  illegal funct3 or timeout.
- mem_read_en  out  1  read strobe to data memory.
- mem_write_en  out  1  write strobe to data memory.
- mem_address  out  ADDR_W  word-aligned address, {addr[ADDR_W-1:2],2'b00}.
- mem_write_data  out  32  lane-replicated store data.
- mem_byte_en  out  4  byte-lane enables.
- mem_read_data  in  32  memory read word.
- mem_ready  in  1  memory completes the access this cycle. Tie to 1 for a combinational-read memory.

Behaviour:
- Reset (async, rst_n=0):
  - State = IDLE.
  - All outputs 0 except req_ready=1.
  - Timeout counter cleared.
  - Reset mid-ACCESS abandons the access. Any write strobe drops immediately.
- FSM states: IDLE, ACCESS, RESP.
- IDLE:
  - req_ready=1.
  - On req_valid, register is_store, funct3, addr and wdata.
  - Illegal funct3 (store with funct3 other than 000/001/010; load with 011, 110 or 111): go to RESP with resp_err=1.
  - Misaligned (H/HU with addr[0]=1; W with addr[1:0]!=0): go to RESP with resp_misaligned=1.
  - Otherwise go to ACCESS.
- ACCESS:
  - Drive mem_* from the registered request.
  - Exactly one of mem_read_en / mem_write_en is high.
  - Hold all mem_* outputs stable until mem_ready.
  - On mem_ready: capture the extended mem_read_data (loads) and go to RESP.
  - The counter increments each cycle without mem_ready. When it reaches TIMEOUT_CYCLES (if nonzero), deassert the strobes and go to RESP with resp_err=1.
- RESP:
  - resp_valid=1 for exactly one cycle, then IDLE.
  - resp_* outputs are registered and hold until the next response. Consumers must sample only on resp_valid.
- Latency with mem_ready tied high:
  - Accept at cycle N, memory access at N+1, resp_valid at N+2.
  - Peak throughput is one request per 3 cycles.
  - Error responses: resp_valid at N+1.
- Store lanes:
  - SB: byte replicated to all 4 lanes; mem_byte_en = 4'b0001 << addr[1:0].
  - SH: halfword replicated to both halves; mem_byte_en = addr[1] ? 1100 : 0011.
  - SW: data unchanged; mem_byte_en = 1111.
- Loads:
  - mem_byte_en = 1111.
  - Select the byte/half by addr[1:0]/addr[1].
  - B/H sign-extend; BU/HU zero-extend.
- Requests while not in IDLE are ignored. The pipeline must hold req_* until req_ready && req_valid.
- mem_ready outside ACCESS is ignored.

Decomposition:
- Package lsu_pkg holds:
  - funct3 constants: F3_B, F3_H, F3_W, F3_BU, F3_HU.
  - State encoding: IDLE, ACCESS, RESP.
- Sub-module lsu_align (combinational) handles:
  - store lane replication and byte-enable generation;
  - load lane select and extension;
  - misalign/illegal detection.
- The FSM, registers and counter stay in load_store_unit.

Test Plan:
1. SW addr 0x10, wdata 0xDEADBEEF, mem_ready=1 -> mem_write_en=1, mem_address 0x10, byte_en 1111; resp_valid 2 cycles after accept, resp_rdata 0.
2. SB addr 0x13, wdata 0x000000A5 -> mem_write_data 0xA5A5A5A5, byte_en 1000, mem_address 0x10.
3. mem_read_data 0x80FF7F01: LB 0x13 -> 0xFFFFFF80; LBU 0x13 -> 0x00000080; LH 0x12 -> 0xFFFF80FF; LHU 0x10 -> 0x00007F01.
4. LW addr 0x22 -> resp_misaligned=1 one cycle after accept; no mem_read_en pulse. Load funct3 011 -> resp_err=1.
5. mem_ready held low for 3 cycles on LW 0x40 -> mem_* stable; resp_valid 1 cycle after mem_ready. With mem_ready held low and TIMEOUT_CYCLES=16 -> resp_err=1 after 16 ACCESS cycles.
6. Assert rst_n=0 mid-ACCESS of SW -> mem_write_en drops immediately; req_ready=1 and resp_valid=0 after release.
